// File: rtl/mult_8x8_prod_accum_if.sv
// Valid/ready bundle between the 8x8 multiplier, the product accumulator and its result consumer.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface mult_8x8_prod_accum_if #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_product;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/mult_8x8_prod_accum.sv
// Accumulates a frame of up to LEN 16-bit products into an ACC_W-bit sum and holds the result
// until taken. Define PROD_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module mult_8x8_prod_accum #(
   parameter int LEN   = 8,
   parameter int ACC_W = 24,
   parameter int CNT_W = 4
) (
   input logic                  clk,
   input logic                  rst,
   mult_8x8_prod_accum_if.slave bus
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf_r;
   logic [ACC_W:0]   add_full;
   logic [ACC_W-1:0] acc_add;
   logic             carry;
   logic             accept;
   logic             closing;

   generate
      if (LEN < 1 || LEN > (1 << CNT_W) - 1) begin : g_bad_cfg
         $error("mult_8x8_prod_accum: CNT_W=%0d cannot represent LEN=%0d", CNT_W, LEN);
      end
   endgenerate

   assign accept  = bus.in_valid && (state == ST_ACC);
   assign closing = bus.in_last || (cnt == CNT_W'(LEN - 1));

   always_comb begin
      add_full = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, bus.in_product};
      carry    = add_full[ACC_W];
`ifdef PROD_ACCUM_SATURATE_EN
      // Once clamped the sum stays at full scale for the rest of the frame.
      acc_add  = (carry || ovf_r) ? '1 : add_full[ACC_W-1:0];
`else
      acc_add  = add_full[ACC_W-1:0];
`endif
   end

   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      case (state)
         ST_ACC: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && closing) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) state_nxt = ST_ACC;
         end
         default: state_nxt = ST_ACC;
      endcase
   end

   // NOTE: rst is sampled inside the clocked block only; adding it to the sensitivity list would make it asynchronous.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_ACC;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc           <= '0;
         cnt           <= '0;
         ovf_r         <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_count <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  if (closing) begin
                     bus.out_sum   <= acc_add;
                     bus.out_count <= cnt + CNT_W'(1);
                     bus.out_ovf   <= ovf_r | carry;
                     bus.out_valid <= 1'b1;
                  end else begin
                     acc   <= acc_add;
                     cnt   <= cnt + CNT_W'(1);
                     ovf_r <= ovf_r | carry;
                  end
               end
            end
            ST_HOLD: begin
               // The running state is cleared only when the result is taken, never at close.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  acc           <= '0;
                  cnt           <= '0;
                  ovf_r         <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_8x8_prod_accum.sv
// Bench for mult_8x8_prod_accum: a 24-bit and a 17-bit instance share one stimulus stream and
// are compared every cycle against a frame-level arithmetic model. Honours PROD_ACCUM_SATURATE_EN.
module tb_mult_8x8_prod_accum;

   localparam int LEN     = 8;
   localparam int CNT_W   = 4;
   localparam int W_A     = 24;
   localparam int W_B     = 17;
   localparam int TIMEOUT = 200;
   localparam int N_RAND  = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [15:0] in_product;
   logic        out_ready;
   bit          rand_ready = 1'b0;

   always #5 clk = ~clk;

   mult_8x8_prod_accum_if #(.ACC_W(W_A), .CNT_W(CNT_W)) bus_a ();
   mult_8x8_prod_accum_if #(.ACC_W(W_B), .CNT_W(CNT_W)) bus_b ();

   assign bus_a.in_valid   = in_valid;
   assign bus_a.in_last    = in_last;
   assign bus_a.in_product = in_product;
   assign bus_a.out_ready  = out_ready;
   assign bus_b.in_valid   = in_valid;
   assign bus_b.in_last    = in_last;
   assign bus_b.in_product = in_product;
   assign bus_b.out_ready  = out_ready;

   mult_8x8_prod_accum #(.LEN(LEN), .ACC_W(W_A), .CNT_W(CNT_W)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   mult_8x8_prod_accum #(.LEN(LEN), .ACC_W(W_B), .CNT_W(CNT_W)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
      end
   endtask

   // Frame-level model: collect the true sum of a frame, fold it to each width when it closes.
   bit     m_live = 1'b0;
   bit     m_hold = 1'b0;
   longint m_total;
   int     m_n;
   int     m_frames = 0;
   longint e_sum_a, e_sum_b;
   int     e_count;
   bit     e_ovf_a, e_ovf_b;

   function automatic longint fold(input longint total, input int w, output bit ovf);
      longint lim;
      lim = longint'(1) << w;
      ovf = (total >= lim);
`ifdef PROD_ACCUM_SATURATE_EN
      return ovf ? lim - 1 : total;
`else
      return total % lim;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_live  = 1'b1;
         m_hold  = 1'b0;
         m_total = 0;
         m_n     = 0;
      end else if (m_live) begin
         if (!m_hold) begin
            if (in_valid) begin
               m_total += longint'(in_product);
               m_n++;
               if (in_last || m_n == LEN) begin
                  e_sum_a  = fold(m_total, W_A, e_ovf_a);
                  e_sum_b  = fold(m_total, W_B, e_ovf_b);
                  e_count  = m_n;
                  m_hold   = 1'b1;
                  m_total  = 0;
                  m_n      = 0;
                  m_frames++;
               end
            end
         end else if (out_ready) begin
            m_hold = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("in_ready_a", bus_a.in_ready, !m_hold);
         check("in_ready_b", bus_b.in_ready, !m_hold);
         check("out_valid_a", bus_a.out_valid, m_hold);
         check("out_valid_b", bus_b.out_valid, m_hold);
         if (m_hold) begin
            check("out_sum_a", bus_a.out_sum, e_sum_a);
            check("out_sum_b", bus_b.out_sum, e_sum_b);
            check("out_count_a", bus_a.out_count, e_count);
            check("out_count_b", bus_b.out_count, e_count);
            check("out_ovf_a", bus_a.out_ovf, e_ovf_a);
            check("out_ovf_b", bus_b.out_ovf, e_ovf_b);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and return just after the edge that accepts it.
   task automatic send(input logic [15:0] p, input logic last);
      logic rdy;
      in_valid   = 1'b1;
      in_product = p;
      in_last    = last;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         rdy = bus_a.in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         if (t >= TIMEOUT) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", TIMEOUT);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input longint sum_a, input longint sum_b,
                               input int count, input bit ovf_b);
      check({tag, "_valid"}, bus_a.out_valid, 1'b1);
      check({tag, "_sum_a"}, bus_a.out_sum, sum_a);
      check({tag, "_sum_b"}, bus_b.out_sum, sum_b);
      check({tag, "_count"}, bus_a.out_count, count);
      check({tag, "_ovf_b"}, bus_b.out_ovf, ovf_b);
      check({tag, "_model_sum"}, e_sum_a, sum_a);
   endtask

   initial begin : main
      int start_frames;
      int iter;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_product = '0;
      out_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("rst_in_ready", bus_a.in_ready, 1'b1);
      check("rst_out_valid", bus_a.out_valid, 1'b0);
      check("rst_out_sum", bus_a.out_sum, 0);
      check("rst_out_count", bus_a.out_count, 0);
      check("rst_out_ovf", bus_a.out_ovf, 1'b0);

      // Full frame: 8 x 255*255; 520200 mod 2^17 = 126984 with a wrap on the narrow instance.
      for (int i = 0; i < LEN; i++) send(16'd65025, 1'b0);
`ifdef PROD_ACCUM_SATURATE_EN
      check_result("full", 520200, 131071, 8, 1'b1);
`else
      check_result("full", 520200, 126984, 8, 1'b1);
`endif
      check("full_ovf_a", bus_a.out_ovf, 1'b0);
      tick();

      send(16'd1, 1'b0);
      send(16'd2, 1'b0);
      send(16'd3, 1'b1);
      check_result("early", 6, 6, 3, 1'b0);
      tick();
      send(16'd5, 1'b1);
      check_result("single", 5, 5, 1, 1'b0);
      tick();

      // Backpressure: stalled beats must not enter the next frame.
      out_ready = 1'b0;
      send(16'd10, 1'b0);
      send(16'd20, 1'b1);
      in_valid   = 1'b1;
      in_product = 16'd7;
      in_last    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_in_ready", bus_a.in_ready, 1'b0);
         check("stall_sum", bus_a.out_sum, 30);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("release_in_ready", bus_a.in_ready, 1'b1);
      check("release_out_valid", bus_a.out_valid, 1'b0);
      send(16'd9, 1'b1);
      check_result("post_stall", 9, 9, 1, 1'b0);
      tick();

      // Overflow of the 17-bit instance: 3 x 65535 = 196605.
      send(16'd65535, 1'b0);
      send(16'd65535, 1'b0);
      send(16'd65535, 1'b1);
`ifdef PROD_ACCUM_SATURATE_EN
      check_result("ovf", 196605, 131071, 3, 1'b1);
`else
      check_result("ovf", 196605, 65533, 3, 1'b1);
`endif
      check("ovf_a_clear", bus_a.out_ovf, 1'b0);
      tick();

      // Reset mid-frame discards the partial sum.
      for (int i = 0; i < 4; i++) send(16'd100, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", bus_a.out_valid, 1'b0);
      check("midrst_in_ready", bus_a.in_ready, 1'b1);
      for (int i = 0; i < LEN; i++) send(16'd1, 1'b0);
      check_result("after_rst", 8, 8, 8, 1'b0);
      tick();

      // Random gaps on both sides, ignored in_last while idle, mixed products.
      start_frames = m_frames;
      rand_ready   = 1'b1;
      iter         = 0;
      while (m_frames - start_frames < N_RAND && iter < 20000) begin
         logic [15:0] p;
         repeat ($urandom_range(0, 2)) begin
            in_last = 1'($urandom_range(0, 1));
            tick();
         end
         in_last = 1'b0;
         case ($urandom_range(0, 3))
            0:       p = 16'hFFFF;
            1:       p = 16'h0000;
            default: p = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
         endcase
         send(p, $urandom_range(0, 4) == 0);
         iter++;
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      repeat (4) tick();
      check("rand_frames_done", (m_frames - start_frames >= N_RAND), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mult_8x8_prod_accum.md
Name: mult_8x8_prod_accum

Overview:
Downstream consumer of the 8x8 unsigned multiplier's 16-bit product. Accumulates a frame of products into a wide running sum, which builds dot products and MAC results from the combinational multiplier. Input and output both use valid/ready handshakes. A frame ends after LEN beats, or early on in_last. The result is held until the consumer takes it.

Parameters:
LEN, 8, maximum number of products per frame (>=1)
ACC_W, 24, accumulator and out_sum width (>=16)
CNT_W, 4, width of the beat counter and out_count; must represent LEN

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a beat
in_product  input  16  unsigned product from the multiplier
in_last  input  1  beat closes the frame early; sampled only on an accepted beat
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts the result
out_sum  output  ACC_W  accumulated sum of the frame
out_count  output  CNT_W  number of beats in the frame (1..LEN)
out_ovf  output  1  sticky flag: an accumulate in this frame carried out of ACC_W

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- Accept: a beat is accepted when in_valid && in_ready at the clock edge.
- State ACC (in_ready=1):
  - Accepted beat, not closing: acc <= acc + zero-extended in_product; cnt <= cnt+1; ovf_r |= carry-out.
  - Closing beat (in_last=1 or cnt==LEN-1): out_sum <= acc + in_product; out_count <= cnt+1; out_ovf <= ovf_r | carry; out_valid <= 1; next state HOLD.
  - No accepted beat: all registers hold.
- State HOLD (in_ready=0, out_valid=1):
  - out_sum, out_count and out_ovf are stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0; acc, cnt and ovf_r cleared; next state ACC.
  - in_ready rises the cycle after the handshake. There is no same-cycle bypass.
- Latency: result visible the cycle after the closing beat is accepted. Minimum frame period is LEN+1 cycles.
- Width rule: in the default build, accumulation wraps modulo 2^ACC_W.
- in_last on the first beat gives a frame of count 1 with out_sum=in_product.
- in_last together with cnt==LEN-1 closes the frame once; no extra frame is produced.
- in_last with in_valid=0 is ignored.
- Reset mid-frame or during HOLD: the partial or pending frame is discarded. The next frame starts from zero.
- out_count wraps only if CNT_W cannot hold LEN, which is an illegal configuration; an optional elaboration check flags it.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output except in_ready, which is derived from state alone.

Optional Feature:
Macro PROD_ACCUM_SATURATE_EN.
- Defined: on carry-out, the sum clamps to 2^ACC_W-1 and stays clamped for the rest of the frame. out_ovf is still set.
- Undefined: the sum wraps modulo 2^ACC_W and out_ovf reports the wrap.
- Handshake and timing are identical in both builds.

Test Plan:
- Full frame: 8 beats of 65025, out_ready=1 -> out_sum=520200 (0x7F008), out_count=8, out_ovf=0; out_valid high one cycle after the 8th beat.
- Early close: beats 1, 2, 3 with in_last on the 3rd -> out_sum=6, out_count=3; the next frame starts fresh (beat 5 alone with in_last gives out_sum=5, count=1).
- Backpressure: hold out_ready=0 for 5 cycles after the frame closes -> in_ready=0 throughout, outputs stable, beats offered during the stall are not consumed; out_ready=1 -> in_ready=1 on the next cycle.
- Overflow with ACC_W=17: 3 beats of 65535 with in_last on the 3rd:
  - Default build -> out_sum=65533, out_ovf=1.
  - With PROD_ACCUM_SATURATE_EN -> out_sum=131071, out_ovf=1.
- Reset mid-frame: 4 beats of 100, then rst for 1 cycle -> out_valid=0, in_ready=1; then 8 beats of 1 -> out_sum=8, out_count=8.
- Random valid/ready gaps over 200 frames -> every out_sum matches a reference model; no beat is lost or duplicated.
